// File: rtl/sht40_i2c_pkg.sv
// sht40_i2c_pkg: shared FSM states, default address and CRC-8 constants for the SHT40 I2C target.
package sht40_i2c_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
   } state_t;
   localparam logic [6:0] DEF_TGT_ADDR = 7'h44;
   localparam logic [7:0] CRC_POLY     = 8'h31;
   localparam logic [7:0] CRC_INIT     = 8'hFF;
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
      return c;
   endfunction
endpackage

// File: rtl/sht40_crc8.sv
// sht40_crc8: bytewise CRC-8 (poly 0x31, init 0xFF) with a running register; only built with SHT40_TGT_CRC_EN.
module sht40_crc8
   import sht40_i2c_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clear,
   input  logic       i_update,
   input  logic [7:0] i_byte,
   output logic [7:0] o_crc
);
   logic [7:0] r_crc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_crc <= CRC_INIT;
      else if (i_clear) r_crc <= CRC_INIT;
      else if (i_update) r_crc <= crc8_next(r_crc, i_byte);
   end
   assign o_crc = r_crc;
endmodule

// File: rtl/sht40_i2c_target.sv
// sht40_i2c_target: SHT40-style I2C target; accepts command bytes, returns resp_data on reads.
// Optional feature: define SHT40_TGT_CRC_EN to replace bytes 2 and 5 with CRC-8 of the preceding pair.
module sht40_i2c_target
   import sht40_i2c_pkg::*;
#(
   parameter logic [6:0] TGT_ADDR   = DEF_TGT_ADDR,
   parameter int          RESP_BYTES = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [47:0] resp_data,
   output logic [7:0]  cmd_byte,
   output logic        cmd_valid,
   output logic        busy
);
   localparam logic [2:0] LAST_IDX = 3'(RESP_BYTES - 1);
   state_t      r_state, w_nx;
   logic [1:0]  r_scl_s, r_sda_s;
   logic        r_scl_d, r_sda_d;
   logic        w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [2:0]  r_cnt, r_idx, w_ld_idx;
   logic [6:0]  r_shift, r_tx;
   logic [7:0]  w_byte, w_load, r_cmd;
   logic [7:0]  w_resp_b [6];
   logic [47:0] r_resp;
   logic        r_rw, r_ack, r_sda_oe, r_cmd_valid, r_busy, w_load_en;
   assign w_scl      = r_scl_s[1];
   assign w_sda      = r_sda_s[1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_byte     = {r_shift, w_sda};
   assign w_ld_idx   = (r_state == S_ADDR_ACK) ? 3'd0 : r_idx + 3'd1;
   assign w_load_en  = w_scl_fall & r_ack & (((r_state == S_ADDR_ACK) & r_rw) | (r_state == S_TX_ACK));
   always_comb begin
      for (int k = 0; k < 6; k++) w_resp_b[k] = r_resp[47 - 8*k -: 8];
   end
`ifdef SHT40_TGT_CRC_EN
   logic [7:0] w_crc;
   logic       w_crc_slot;
   assign w_crc_slot = (w_ld_idx == 3'd2) | (w_ld_idx == 3'd5);
   assign w_load     = w_crc_slot ? w_crc : w_resp_b[w_ld_idx];
   sht40_crc8 u_crc (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_start | (w_load_en & w_crc_slot)),
      .i_update (w_load_en & ~w_crc_slot),
      .i_byte   (w_resp_b[w_ld_idx]),
      .o_crc    (w_crc)
   );
`else
   assign w_load = w_resp_b[w_ld_idx];
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else r_state <= w_nx;
   end
   always_comb begin
      w_nx = r_state;
      if (w_stop) w_nx = S_IDLE;
      else if (w_start) w_nx = S_ADDR;
      else case (r_state)
         S_ADDR:     if (w_scl_rise && r_cnt == 3'd7) w_nx = (w_byte[7:1] == TGT_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
         S_ADDR_ACK: if (w_scl_fall && r_ack) w_nx = r_rw ? S_TX : S_CMD;
         S_CMD:      if (w_scl_rise && r_cnt == 3'd7) w_nx = S_CMD_ACK;
         S_CMD_ACK:  if (w_scl_fall && r_ack) w_nx = S_CMD;
         S_TX:       if (w_scl_fall && r_cnt == 3'd7) w_nx = S_TX_ACK;
         S_TX_ACK:   if (w_scl_rise && (w_sda || r_idx == LAST_IDX)) w_nx = S_WAIT_STOP;
                     else if (w_load_en) w_nx = S_TX;
         default:    ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_s     <= 2'b11;
         r_sda_s     <= 2'b11;
         r_scl_d     <= 1'b1;
         r_sda_d     <= 1'b1;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_tx        <= '0;
         r_resp      <= '0;
         r_cmd       <= '0;
         r_rw        <= 1'b0;
         r_ack       <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_scl_s     <= {r_scl_s[0], scl_in};
         r_sda_s     <= {r_sda_s[0], sda_in};
         r_scl_d     <= w_scl;
         r_sda_d     <= w_sda;
         r_cmd_valid <= 1'b0;
         if (w_start || w_stop) begin
            r_cnt    <= '0;
            r_ack    <= 1'b0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else case (r_state)
            S_ADDR, S_CMD: if (w_scl_rise) begin
               r_shift <= w_byte[6:0];
               r_cnt   <= r_cnt + 3'd1;
               r_ack   <= 1'b0;
               if (r_cnt == 3'd7 && r_state == S_CMD) begin
                  r_cmd       <= w_byte;
                  r_cmd_valid <= 1'b1;
               end
               if (w_nx == S_ADDR_ACK) begin
                  r_rw   <= w_sda;
                  r_busy <= 1'b1;
                  r_resp <= resp_data;
               end
            end
            S_ADDR_ACK, S_CMD_ACK, S_TX_ACK: begin
               if (r_state == S_TX_ACK && w_scl_rise) r_ack <= ~w_sda;
               else if (w_scl_fall && r_state != S_TX_ACK) begin
                  r_ack    <= 1'b1;
                  r_sda_oe <= ~r_ack;
               end
               // A load starts the next byte: MSB goes straight onto the bus
               if (w_load_en) begin
                  r_idx    <= w_ld_idx;
                  r_tx     <= w_load[6:0];
                  r_sda_oe <= ~w_load[7];
                  r_cnt    <= '0;
               end
            end
            S_TX: if (w_scl_fall) begin
               r_cnt    <= r_cnt + 3'd1;
               r_tx     <= {r_tx[5:0], 1'b1};
               r_sda_oe <= (r_cnt == 3'd7) ? 1'b0 : ~r_tx[6];
               if (r_cnt == 3'd7) r_ack <= 1'b0;
            end
            default: r_sda_oe <= 1'b0;
         endcase
      end
   end
   assign sda_oe    = r_sda_oe;
   assign cmd_byte  = r_cmd;
   assign cmd_valid = r_cmd_valid;
   assign busy      = r_busy;
endmodule

// File: tb/tb_sht40_i2c_target.sv
// tb_sht40_i2c_target: directed and randomized I2C master transfers checked against a byte-level response model.
module tb_sht40_i2c_target;
   localparam int Q = 5;
   logic        clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
   logic        sda_in, sda_oe, cmd_valid, busy;
   logic [7:0]  cmd_byte;
   logic [47:0] resp_data = '0;
   int          n_vec = 0, n_err = 0, n_cv = 0;
   assign sda_in = m_sda & ~sda_oe;
   always #5 clk = ~clk;
   always @(posedge clk) if (cmd_valid) n_cv++;
   sht40_i2c_target dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (m_scl),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .resp_data (resp_data),
      .cmd_byte  (cmd_byte),
      .cmd_valid (cmd_valid),
      .busy      (busy)
   );
   function automatic logic [7:0] crc_pair(input logic [7:0] x, input logic [7:0] y);
      logic [7:0]  c = 8'hFF;
      logic [15:0] m = {x, y};
      for (int i = 15; i >= 0; i--) c = (c[7] ^ m[i]) ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
      return c;
   endfunction
   // Bytes the master should see on the wire for a given resp_data
   function automatic logic [47:0] model(input logic [47:0] r);
      logic [7:0] b [6];
      for (int k = 0; k < 6; k++) b[k] = r[47 - 8*k -: 8];
`ifdef SHT40_TGT_CRC_EN
      b[2] = crc_pair(b[0], b[1]);
      b[5] = crc_pair(b[3], b[4]);
`endif
      return {b[0], b[1], b[2], b[3], b[4], b[5]};
   endfunction
   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic i2c_start;
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask
   task automatic i2c_stop;
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask
   task automatic bit_xfer(input logic b, output logic r);
      m_sda = b;    tick(Q);
      m_scl = 1'b1; tick(Q);
      r = sda_in;   tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask
   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
      bit_xfer(1'b1, ack);
   endtask
   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
      bit_xfer(~mack, r);
   endtask
   task automatic read_xfer(input int nb, input logic last_ack, output logic aack, output logic [47:0] got);
      logic [7:0] b;
      got = '0;
      i2c_start;
      wr_byte({7'h44, 1'b1}, aack);
      for (int k = 0; k < nb; k++) begin
         rd_byte((k < nb - 1) ? 1'b1 : last_ack, b);
         got[47 - 8*k -: 8] = b;
      end
   endtask
   initial begin
      logic        a, r, acc;
      logic [7:0]  d, d2, x;
      logic [6:0]  wa;
      logic [47:0] got, rs, exp_c;
      int          cv0, nb;
      tick(3);
      chk("rst_sda_oe", 48'(sda_oe), 48'h0);
      chk("rst_busy", 48'(busy), 48'h0);
      chk("rst_cmd_byte", 48'(cmd_byte), 48'h0);
      chk("rst_cmd_valid", 48'(cmd_valid), 48'h0);
      rst_n = 1'b1;
      tick(3);
      cv0 = n_cv;
      i2c_start;
      wr_byte({7'h44, 1'b0}, a);
      chk("wr_addr_ack", 48'(a), 48'h0);
      chk("wr_busy", 48'(busy), 48'h1);
      wr_byte(8'h88, a);
      chk("wr_cmd_ack", 48'(a), 48'h0);
      chk("wr_cmd_byte", 48'(cmd_byte), 48'h88);
      chk("wr_cv_pulses", 48'(n_cv - cv0), 48'h1);
      i2c_stop;
      tick(2);
      chk("wr_stop_busy", 48'(busy), 48'h0);
      for (int t = 0; t < 3; t++) begin
         d = 8'($urandom);
         d2 = 8'($urandom);
         cv0 = n_cv;
         i2c_start;
         wr_byte({7'h44, 1'b0}, a);
         wr_byte(d, r);
         chk("wr_rand_ack", {46'h0, a, r}, 48'h0);
         chk("wr_rand_byte", 48'(cmd_byte), 48'(d));
         wr_byte(d2, r);
         chk("wr_rand_byte2", {39'h0, r, cmd_byte}, {40'h0, d2});
         chk("wr_rand_cv", 48'(n_cv - cv0), 48'h2);
         i2c_stop;
      end
      resp_data = 48'hBEEF00666600;
`ifdef SHT40_TGT_CRC_EN
      exp_c = 48'hBEEF92666693;
`else
      exp_c = 48'hBEEF00666600;
`endif
      read_xfer(6, 1'b0, a, got);
      chk("rd_fixed_ack", 48'(a), 48'h0);
      chk("rd_fixed_const", got, exp_c);
      chk("rd_fixed_model", got, model(resp_data));
      bit_xfer(1'b1, r);
      chk("rd_fixed_released", 48'(r), 48'h1);
      i2c_stop;
      for (int t = 0; t < 4; t++) begin
         rs = {16'($urandom), $urandom};
         resp_data = rs;
         nb = $urandom_range(1, 6);
         read_xfer(nb, 1'b0, a, got);
         chk("rd_rand_ack", 48'(a), 48'h0);
         chk("rd_rand_busy", 48'(busy), 48'h1);
         resp_data = ~rs;
         chk("rd_rand_data", got >> (8*(6 - nb)), model(rs) >> (8*(6 - nb)));
         i2c_stop;
         tick(2);
         chk("rd_rand_stop_busy", 48'(busy), 48'h0);
      end
      rs = {16'($urandom), $urandom};
      resp_data = rs;
      read_xfer(6, 1'b1, a, got);
      chk("rd_sat_data", got, model(rs));
      rd_byte(1'b1, x);
      chk("rd_sat_ff", 48'(x), 48'hFF);
      i2c_stop;
      cv0 = n_cv;
      i2c_start;
      wr_byte({7'h45, 1'b0}, a);
      chk("bad_addr_nack", 48'(a), 48'h1);
      chk("bad_addr_busy", 48'(busy), 48'h0);
      wr_byte(8'h12, a);
      chk("bad_addr_data_nack", 48'(a), 48'h1);
      chk("bad_addr_no_cv", 48'(n_cv - cv0), 48'h0);
      i2c_stop;
      for (int t = 0; t < 2; t++) begin
         do wa = 7'($urandom); while (wa == 7'h44);
         i2c_start;
         wr_byte({wa, 1'b1}, a);
         rd_byte(1'b1, x);
         chk("bad_rand_addr", {39'h0, a, x}, {39'h0, 1'b1, 8'hFF});
         i2c_stop;
      end
      rs = {16'($urandom), $urandom};
      resp_data = rs;
      read_xfer(1, 1'b0, a, got);
      chk("nack0_byte", got[47:40], model(rs) >> 40);
      rd_byte(1'b1, x);
      chk("nack0_released", 48'(x), 48'hFF);
      i2c_stop;
      tick(2);
      chk("nack0_idle_busy", 48'(busy), 48'h0);
      rs = {16'($urandom), $urandom};
      resp_data = rs;
      i2c_start;
      wr_byte({7'h44, 1'b0}, a);
      wr_byte(8'hFD, r);
      chk("rs_wr_ack", {46'h0, a, r}, 48'h0);
      chk("rs_cmd", 48'(cmd_byte), 48'hFD);
      read_xfer(6, 1'b0, a, got);
      chk("rs_rd_ack", 48'(a), 48'h0);
      chk("rs_rd_data", got, model(rs));
      i2c_stop;
      resp_data = {8'h00, 8'($urandom), $urandom};
      i2c_start;
      wr_byte({7'h44, 1'b1}, a);
      for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
      chk("rstx_driving", 48'(sda_oe), 48'h1);
      #2 rst_n = 1'b0;
      #1 chk("rstx_sda_oe", {46'h0, sda_oe, busy}, 48'h0);
      tick(2);
      rst_n = 1'b1;
      acc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bit_xfer(1'b1, r);
         acc = acc & r;
      end
      chk("rstx_idle_after", 48'(acc), 48'h1);
      i2c_stop;
      rs = {16'($urandom), $urandom};
      resp_data = rs;
      read_xfer(6, 1'b0, a, got);
      chk("rstx_next_read", {got, 7'h0, a} >> 8, model(rs));
      chk("rstx_next_ack", 48'(a), 48'h0);
      i2c_stop;
      tick(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sht40_i2c_target.md
SHT40_I2C_TARGET -- requirements
Module: sht40_i2c_target

Interface
REQ-001 SHALL have parameter TGT_ADDR, default 7'h44, the 7-bit I2C address this block answers to.
REQ-002 SHALL have parameter RESP_BYTES, default 6, the number of bytes returned per read transfer (range 1..6).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port scl_in, input, 1, sampled bus SCL (asynchronous to clk).
REQ-006 SHALL have port sda_in, input, 1, sampled bus SDA (asynchronous to clk).
REQ-007 SHALL have port sda_oe, output, 1, open-drain pull-down enable; 1 = drive SDA low, 0 = release.
REQ-008 SHALL have port resp_data, input, 48, response bytes, MSB byte sent first; captured on address match.
REQ-009 SHALL have port cmd_byte, output, 8, last command byte written by the master.
REQ-010 SHALL have port cmd_valid, output, 1, one-clk pulse when cmd_byte updates.
REQ-011 SHALL have port busy, output, 1, high from address match until STOP or START.

Function
REQ-012 SHALL pass scl_in/sda_in through 2-flop synchronizers, then an edge-detect register; all decisions use synchronized values.
REQ-013 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-014 SHALL sample SDA bits on SCL rising edges, MSB first, and change sda_oe only on the clk following an SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACK, WAIT_STOP.
REQ-016 IDLE: START -> ADDR with bit counter cleared.
REQ-017 ADDR: after 8 bits, address == TGT_ADDR -> ADDR_ACK (R/W bit latched); mismatch -> WAIT_STOP with sda_oe=0.
REQ-018 ADDR_ACK: sda_oe=1 from the SCL falling edge after bit 8 until the next SCL falling edge; then W -> CMD, R -> TX with resp_data latched and byte index 0.
REQ-019 CMD: after 8 bits -> CMD_ACK; cmd_byte updated and cmd_valid pulsed exactly once at the 8th SCL rising edge.
REQ-020 CMD_ACK: ACK as in REQ-018, then -> CMD for further command bytes.
REQ-021 TX: drive sda_oe = ~bit for 8 bits; after the 8th SCL falling edge release SDA and -> TX_ACK.
REQ-022 TX_ACK: master ACK (SDA=0 at SCL rise) and index < RESP_BYTES-1 -> TX with next byte; NACK or last byte sent -> WAIT_STOP.
REQ-023 WAIT_STOP: sda_oe=0; ignores SCL activity.
REQ-024 STOP in any state -> IDLE, sda_oe=0 on the next clk; START (repeated) in any state -> ADDR, sda_oe=0.
REQ-025 Byte index saturates; further master ACKs past RESP_BYTES send 0xFF (SDA released).
REQ-026 SHALL never stretch SCL (no SCL drive).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, sda_oe=0, cmd_byte=8'h00, cmd_valid=0, busy=0, and synchronizer flops to 1 (idle bus).
REQ-028 Deassertion mid-transfer SHALL leave the block in IDLE until the next START.

Configuration
REQ-029 Macro SHT40_TGT_CRC_EN: when defined, bytes 2 and 5 (0-based) SHALL be replaced by CRC-8 (poly 0x31, init 0xFF, no reflection, no xor-out) over the preceding two transmitted bytes.
REQ-030 Without SHT40_TGT_CRC_EN, all bytes SHALL be sent verbatim from resp_data and no CRC logic SHALL be present.

Structure
REQ-031 Shared package sht40_i2c_pkg SHALL hold the state enum, default address 7'h44, CRC_POLY 8'h31 and CRC_INIT 8'hFF.
REQ-032 Sub-module sht40_crc8 (bytewise combinational CRC-8 plus running register) SHALL be instantiated only under SHT40_TGT_CRC_EN.

Verification
REQ-033 Write 0x88 to addr 0x44 -> ACK on both bytes, cmd_byte=0x88, one cmd_valid pulse.
REQ-034 Read addr 0x44, resp_data=48'hBEEF00_6666_00, CRC on, master ACKs 5 then NACK -> bytes BE EF 92 66 66 93, then SDA released.
REQ-035 Address 0x45 -> NACK (SDA high at 9th clock), busy stays 0, no cmd_valid.
REQ-036 Read with NACK after byte 0 -> SDA released, no further bytes driven; STOP -> IDLE.
REQ-037 Repeated START after write 0xFD then read -> second transfer ACKed and data returned without an intervening STOP.
REQ-038 rst_n asserted during TX bit 3 -> sda_oe=0 immediately; next full read transfers correctly.
